// File: rtl/sm_serial_subtractor.sv
// Sign-magnitude subtractor: diff = a - b, computed one magnitude bit per clock
// through a 1-bit full adder / full subtractor after a one-cycle compare stage.
module sm_serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] diff
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SER  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'd5;

  state_t     state;
  state_t     state_nxt;

  // Operands captured on the start edge; later changes on a/b are invisible.
  logic [6:0] a_q;
  logic [6:0] b_q;

  // Serial datapath: mag_x is always the minuend (larger magnitude under SUB).
  logic [5:0] mag_x;
  logic [5:0] mag_y;
  logic [5:0] res;
  logic       is_add;
  logic       res_sign;
  logic       cy;
  logic [2:0] cnt;
  logic [7:0] diff_q;

  // Compare-stage decode
  logic       sb;
  logic       cmp_add;
  logic       a_ge;

  // One bit slice of the serial engine
  logic       x_bit;
  logic       y_bit;
  logic       s_bit;
  logic       c_nxt;
  logic [6:0] final_mag;
  logic       final_sign;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CMP;
        end
      end
      CMP: begin
        busy      = 1'b1;
        state_nxt = SER;
      end
      SER: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Compare-stage decode: subtracting b is adding a value of sign ~b[6]
  // ---------------------------------------------------------------------------
  always_comb begin
    sb      = ~b_q[6];
    cmp_add = (a_q[6] == sb);
    a_ge    = (a_q[5:0] >= b_q[5:0]);
  end

  // ---------------------------------------------------------------------------
  // Serial bit slice. Under SUB the minuend is never smaller than the
  // subtrahend, so the final borrow is always zero and is discarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_bit = mag_x[cnt];
    y_bit = mag_y[cnt];
    s_bit = x_bit ^ y_bit ^ cy;
    if (is_add) begin
      c_nxt = (x_bit & y_bit) | (x_bit & cy) | (y_bit & cy);
    end else begin
      c_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & cy);
    end
    final_mag  = {is_add & c_nxt, s_bit, res[4:0]};
    // A zero magnitude is always reported as +0.
    final_sign = res_sign & (|final_mag);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= 7'd0;
      b_q      <= 7'd0;
      mag_x    <= 6'd0;
      mag_y    <= 6'd0;
      res      <= 6'd0;
      is_add   <= 1'b0;
      res_sign <= 1'b0;
      cy       <= 1'b0;
      cnt      <= 3'd0;
      diff_q   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
          end
        end
        CMP: begin
          is_add <= cmp_add;
          cnt    <= 3'd0;
          cy     <= 1'b0;
          res    <= 6'd0;
          if (cmp_add || a_ge) begin
            mag_x <= a_q[5:0];
            mag_y <= b_q[5:0];
          end else begin
            mag_x <= b_q[5:0];
            mag_y <= a_q[5:0];
          end
          if (cmp_add || a_ge) begin
            res_sign <= a_q[6];
          end else begin
            res_sign <= sb;
          end
        end
        SER: begin
          res[cnt] <= s_bit;
          cy       <= c_nxt;
          if (cnt == LAST_BIT) begin
            diff_q <= {final_sign, final_mag};
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = diff_q;

  // ---------------------------------------------------------------------------
  // Embedded protocol properties
  // ---------------------------------------------------------------------------
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  a_done_single:   assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule

// File: tb/tb_sm_serial_subtractor.sv
// Directed bench for sm_serial_subtractor: hand-computed sign-magnitude results,
// cycle-exact latency/busy checks, start masking, mid-operation reset, back-to-back.
module tb_sm_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] a;
  logic [6:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;

  int tests_run;
  int tests_failed;

  sm_serial_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, run required to finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (no checking)
  // ---------------------------------------------------------------------------
  // Presents operands with start, lets the sampling edge E0 pass, drops start.
  // Returns at the falling edge of cycle 1 after E0.
  task automatic launch(input logic [6:0] op_a, input logic [6:0] op_b);
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at cycle 1; returns the cycle number (counted from E0) in which done
  // is seen, or 20 if it never appears within the budget.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = 7'd0;
    b     = 7'd0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    tests_run++;
    if (diff !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_diff: got %h want 00", diff);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  // -21 - (+40) = -61, with cycle-exact busy/done profile
  task automatic test_negative_add();
    logic exp_busy;
    logic exp_done;
    launch(7'b1010101, 7'b0101000);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      exp_busy = (k <= 7);
      exp_done = (k == 8);
      tests_run++;
      if (busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL neg_add_busy_c%0d: got %b want %b", k, busy, exp_busy);
      end
      tests_run++;
      if (done !== exp_done) begin
        tests_failed++;
        $display("FAIL neg_add_done_c%0d: got %b want %b", k, done, exp_done);
      end
    end
    tests_run++;
    if (diff !== 8'b10111101) begin
      tests_failed++;
      $display("FAIL neg_add_diff: got %b want 10111101", diff);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || diff !== 8'b10111101) begin
      tests_failed++;
      $display("FAIL neg_add_after: got done=%b diff=%b want 0/10111101", done, diff);
    end
  endtask

  // +63 - (-63) = +126, carry lands in diff[6]
  task automatic test_carry();
    int cyc;
    launch(7'b0111111, 7'b1111111);
    wait_done(cyc);
    tests_run++;
    if (cyc != 8) begin
      tests_failed++;
      $display("FAIL carry_latency: got %0d want 8", cyc);
    end
    tests_run++;
    if (diff !== 8'b01111110) begin
      tests_failed++;
      $display("FAIL carry_diff: got %b want 01111110", diff);
    end
  endtask

  // Zero results: equal magnitudes under SUB, and -0 - (+0)
  task automatic test_zero();
    int cyc;
    launch(7'b0000101, 7'b0000101);
    tests_run++;
    if (diff !== 8'b01111110) begin
      tests_failed++;
      $display("FAIL diff_hold_midop: got %b want 01111110", diff);
    end
    wait_done(cyc);
    tests_run++;
    if (cyc != 8 || diff !== 8'h00) begin
      tests_failed++;
      $display("FAIL zero_equal: got cyc=%0d diff=%h want 8/00", cyc, diff);
    end
    launch(7'b1000000, 7'b0000000);
    wait_done(cyc);
    tests_run++;
    if (cyc != 8 || diff !== 8'h00) begin
      tests_failed++;
      $display("FAIL zero_negzero: got cyc=%0d diff=%h want 8/00", cyc, diff);
    end
  endtask

  // +3 - (+10) = -7; start and operand changes during SER are ignored
  task automatic test_ignore_start();
    int done_cnt;
    int done_cyc;
    logic [7:0] got;
    done_cnt = 0;
    done_cyc = 0;
    got      = 8'hxx;
    launch(7'b0000011, 7'b0001010);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 3) begin
        start = 1'b1;
        a     = 7'b1111111;
        b     = 7'b0000001;
      end
      if (k == 4) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
        got      = diff;
      end
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 8) begin
      tests_failed++;
      $display("FAIL ignore_start_done: got count=%0d cycle=%0d want 1/8", done_cnt, done_cyc);
    end
    tests_run++;
    if (got !== 8'b10000111) begin
      tests_failed++;
      $display("FAIL ignore_start_diff: got %b want 10000111", got);
    end
  endtask

  // Reset during SER (counter=3) aborts; next op -7 - (+2) = -9
  task automatic test_reset_mid();
    int cyc;
    launch(7'b0010100, 7'b1000110);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got busy=%b done=%b diff=%h want 0/0/00", busy, done, diff);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold: got busy=%b done=%b want 0/0", busy, done);
    end
    rst_n = 1'b1;
    launch(7'b1000111, 7'b0000010);
    wait_done(cyc);
    tests_run++;
    if (cyc != 8 || diff !== 8'b10001001) begin
      tests_failed++;
      $display("FAIL reset_mid_next: got cyc=%0d diff=%b want 8/10001001", cyc, diff);
    end
  endtask

  // start held high: +5-(+3)=+2 then -10-(-4)=-6, one result per 9 cycles
  task automatic test_back_to_back();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    a     = 7'b0000101;
    b     = 7'b0000011;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a = 7'b1001010;
        b = 7'b1000100;
      end
      if (done === 1'b1) done_cnt++;
      if (k == 8) begin
        tests_run++;
        if (done !== 1'b1 || diff !== 8'h02) begin
          tests_failed++;
          $display("FAIL b2b_first: got done=%b diff=%h want 1/02", done, diff);
        end
      end
      if (k == 9) begin
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0/0", busy, done);
        end
      end
      if (k == 10) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_restart: got busy=%b want 1", busy);
        end
      end
      if (k == 17) begin
        start = 1'b0;
        tests_run++;
        if (done !== 1'b1 || diff !== 8'h86) begin
          tests_failed++;
          $display("FAIL b2b_second: got done=%b diff=%h want 1/86", done, diff);
        end
      end
    end
    tests_run++;
    if (done_cnt != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d want 2", done_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_negative_add();
    test_carry();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sm_serial_subtractor.md
SM_SERIAL_SUBTRACTOR -- requirements
Module: sm_serial_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset (clk, rst_n); no other clock or reset SHALL exist.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  7  minuend, sign-magnitude: a[6] sign (1 = negative), a[5:0] magnitude.
REQ-006 b  input  7  subtrahend, same format as a.
REQ-007 busy  output  1  high while an operation is in progress (CMP, SER).
REQ-008 done  output  1  single-cycle pulse when diff is updated.
REQ-009 diff  output  8  result a-b, sign-magnitude: diff[7] sign, diff[6:0] magnitude.

Function
REQ-010 The FSM SHALL have the states IDLE, CMP, SER and DONE, encoded in registers.
REQ-011 IDLE: on a rising edge with start=1, latch a and b, go to CMP; start=0 stays in IDLE.
REQ-012 CMP (1 cycle): effective b sign sb = ~b[6]; if a[6]==sb the op is ADD with result sign a[6], else the op is SUB with the operand of larger magnitude as minuend and its sign (a[6] or sb) as result sign; go to SER with bit counter=0 and carry/borrow=0.
REQ-013 SER (6 cycles): per edge, process magnitude bit [counter], LSB first, via a 1-bit full adder (ADD) or full subtractor (SUB); update carry/borrow; counter increments 0..5; at counter==5 go to DONE.
REQ-014 On entry to DONE, diff[5:0] SHALL equal the serial result, diff[6] the final carry (ADD) or 0 (SUB), and diff[7] the result sign.
REQ-015 Zero result (all magnitude bits 0) SHALL force diff[7]=0; -0 inputs SHALL be treated as +0.
REQ-016 Equal magnitudes under SUB SHALL yield diff=8'h00.
REQ-017 DONE: done=1 for exactly one cycle, busy=0; next state IDLE unconditionally.
REQ-018 Latency: done high in the 8th cycle after the start-sampling edge (edges E1 CMP→SER, E2..E7 serial, DONE after E7).
REQ-019 start SHALL be ignored in CMP, SER and DONE; a/b changes after latching SHALL not affect the result.
REQ-020 diff SHALL hold its value from one DONE to the next; it SHALL change at no other time.
REQ-021 Back-to-back: start held high SHALL begin a new operation on the edge after DONE (IDLE sample), giving a throughput of 1 result per 9 cycles.

Reset
REQ-022 With rst_n=0, asynchronously: state=IDLE, busy=0, done=0, diff=8'h00, counter=0, carry/borrow=0, operand registers=0.
REQ-023 Reset asserted mid-operation SHALL abort it without done; after release the block SHALL accept start on the first sampling edge.

Verification
REQ-024 a=7'b1010101 (-21), b=7'b0101000 (+40), start pulse -> 8 cycles later done=1, diff=8'b10111101 (-61), busy high for the 7 cycles between.
REQ-025 a=7'b0111111 (+63), b=7'b1111111 (-63) -> diff=8'b01111110 (+126), carry into diff[6].
REQ-026 a=7'b0000101, b=7'b0000101, then a=7'b1000000, b=7'b0000000 -> diff=8'h00 both times, never 8'h80.
REQ-027 a=7'b0000011 (+3), b=7'b0001010 (+10) -> diff=8'b10000111 (-7); start re-pulsed during SER with other operands -> ignored, single done.
REQ-028 rst_n pulsed low during SER (counter=3) -> busy/done/diff drop to 0 immediately, no done pulse; next start gives a correct result at nominal latency.
